// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter: FSM state encoding and a width helper.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Unsigned adder primitive: both operands zero-extended to one bit wider than the larger.
module adder #(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16,
  parameter int SUM_WIDTH    = ((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2) + 1
) (
  input  logic [DATA_WIDTH_1-1:0] a_i,
  input  logic [DATA_WIDTH_2-1:0] b_i,
  output logic [SUM_WIDTH-1:0]    sum_o
);

  assign sum_o = SUM_WIDTH'(a_i) + SUM_WIDTH'(b_i);

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin grant: first set request bit at or above ptr_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] grant_idx_o,
  output logic                any_o
);

  logic w_found;
  int   w_k;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    w_found     = 1'b0;
    w_k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(ptr_i) + i) % NUM_REQ;
      if (!w_found && req_i[w_k]) begin
        w_found        = 1'b1;
        grant_o[w_k]   = 1'b1;
        grant_idx_o    = ID_WIDTH'(w_k);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ requesters with round-robin arbitration and
// one transaction in flight (IDLE -> CALC -> DONE).
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [DATA_WIDTH:0]           res_data_o,
  output logic [ID_WIDTH-1:0]           res_id_o,
  output logic                          busy_o
);

  state_e              r_state;
  state_e              w_state_next;
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [ID_WIDTH-1:0] r_id;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH:0] r_res_data;
  logic [ID_WIDTH-1:0] r_res_id;
  logic                r_res_valid;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_WIDTH-1:0] w_grant_idx;
  logic                w_any;
  logic [ID_WIDTH-1:0] w_ptr_next;
  logic [DATA_WIDTH:0] w_sum;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req_i       (req_valid_i),
    .ptr_i       (r_rr_ptr),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx),
    .any_o       (w_any)
  );

  adder #(
    .DATA_WIDTH_1 (DATA_WIDTH),
    .DATA_WIDTH_2 (DATA_WIDTH)
  ) u_adder (
    .a_i   (r_a),
    .b_i   (r_b),
    .sum_o (w_sum)
  );

  assign w_ptr_next = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_WIDTH'(1);

  // Next state; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_next = w_any ? ST_CALC : ST_IDLE;
      ST_CALC: w_state_next = ST_DONE;
      ST_DONE: w_state_next = res_ready_i ? ST_IDLE : ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res_data  <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a      <= req_a_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_b      <= req_b_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_ptr_next;
          end
        end
        ST_CALC: begin
          r_res_data  <= w_sum;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
        end
        ST_DONE: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
          end
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

  // Grant is only offered in IDLE so a waiting requester never sees ready mid-transaction.
  assign req_ready_o = ((r_state == ST_IDLE) && !rst_i) ? w_grant : '0;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_id_o    = r_res_id;
  assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single-requester vector table plus
// round-robin, back-pressure, mid-flight reset and wrap sequences.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_data;
  logic [1:0]  res_id;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [3:0]  valid;
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;
  } vec_t;

  vec_t vecs[6];

  adder_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (16),
    .ID_WIDTH   (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_id_o    (res_id),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k*16 +: 16] = a;
    req_b[k*16 +: 16] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // One complete transaction for a single requester with res_ready held high.
  task automatic single_txn(input int k, input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] sum, input string tag);
    set_ops(k, a, b);
    req_valid = 4'b0001 << k;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << k));
    step();
    req_valid = 4'b0000;
    check({tag, "_calc_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_calc_busy"}, 32'(busy), 32'd1);
    step();
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(sum));
    check({tag, "_id"}, 32'(res_id), 32'(k));
    step();
    check({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{valid: 4'b0001, k: 0, a: 16'd3,      b: 16'd5,      sum: 17'd8};
    vecs[1] = '{valid: 4'b0010, k: 1, a: 16'hFFFF,   b: 16'hFFFF,   sum: 17'h1FFFE};
    vecs[2] = '{valid: 4'b0100, k: 2, a: 16'h0000,   b: 16'h0000,   sum: 17'h00000};
    vecs[3] = '{valid: 4'b1000, k: 3, a: 16'h1234,   b: 16'h4321,   sum: 17'h05555};
    vecs[4] = '{valid: 4'b0010, k: 1, a: 16'h8000,   b: 16'h8000,   sum: 17'h10000};
    vecs[5] = '{valid: 4'b0100, k: 2, a: 16'hFFFF,   b: 16'h0001,   sum: 17'h10000};

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    step();
    step();
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      check($sformatf("vec%0d_mask", v), 32'(vecs[v].valid), 32'(4'b0001 << vecs[v].k));
      single_txn(vecs[v].k, vecs[v].a, vecs[v].b, vecs[v].sum, $sformatf("vec%0d", v));
    end

    // All four requesting continuously: grants 0,1,2,3,0 one every three clocks.
    do_reset();
    for (int k = 0; k < 4; k++) set_ops(k, 16'(k), 16'd10);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      #1;
      check($sformatf("rr%0d_ready", j), 32'(req_ready), 32'(4'b0001 << (j % 4)));
      step();
      check($sformatf("rr%0d_calc", j), 32'(res_valid), 32'd0);
      step();
      check($sformatf("rr%0d_valid", j), 32'(res_valid), 32'd1);
      check($sformatf("rr%0d_id", j), 32'(res_id), 32'(j % 4));
      check($sformatf("rr%0d_data", j), 32'(res_data), 32'(10 + (j % 4)));
      step();
    end
    req_valid = 4'b0000;
    step();

    // Back-pressure: result held while req 2 waits, then req 2 granted.
    do_reset();
    set_ops(0, 16'd100, 16'd23);
    set_ops(2, 16'd7, 16'd9);
    res_ready = 1'b0;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0100;
    step();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_valid", c), 32'(res_valid), 32'd1);
      check($sformatf("bp%0d_data", c), 32'(res_data), 32'd123);
      check($sformatf("bp%0d_id", c), 32'(res_id), 32'd0);
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    step();
    check("bp_after_valid", 32'(res_valid), 32'd0);
    check("bp_after_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    step();
    check("bp_req2_valid", 32'(res_valid), 32'd1);
    check("bp_req2_data", 32'(res_data), 32'd16);
    check("bp_req2_id", 32'(res_id), 32'd2);
    step();

    // Reset during CALC discards the transaction and restarts the pointer.
    single_txn(2, 16'd1, 16'd1, 17'd2, "pre_rst");
    set_ops(1, 16'd50, 16'd50);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    check("mid_calc_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mid_rst_quiet%0d", c), 32'(res_valid), 32'd0);
    end
    req_valid = 4'b1111;
    #1;
    check("mid_rst_ptr0", 32'(req_ready), 32'b0001);
    req_valid = 4'b0000;
    step();

    // Pointer at 3 with requesters 0 and 3 valid: grant 3, then wrap to 0.
    do_reset();
    single_txn(2, 16'd4, 16'd4, 17'd8, "ptr3");
    set_ops(0, 16'd20, 16'd1);
    set_ops(3, 16'd30, 16'd2);
    req_valid = 4'b1001;
    #1;
    check("wrap_grant3", 32'(req_ready), 32'b1000);
    step();
    step();
    check("wrap_id3", 32'(res_id), 32'd3);
    check("wrap_data3", 32'(res_data), 32'd32);
    step();
    #1;
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0000;
    step();
    check("wrap_id0", 32'(res_id), 32'd0);
    check("wrap_data0", 32'(res_data), 32'd21);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
